// File: rtl/symmetric_fir_param.sv
// symmetric_fir_param: transposed linear-phase FIR with folded, runtime-loadable coefficients,
// round-half-up output scaling and optional saturation.
module symmetric_fir_param #(
  parameter int DATA_W = 16,
  parameter int COEFF_W = 16,
  parameter int TAPS = 172,
  parameter int OUT_SHIFT = 15,
  parameter int SAT_EN = 1,
  parameter int ACC_W = DATA_W + COEFF_W + $clog2(TAPS),
  localparam int NU = (TAPS + 1) / 2,
  localparam int AW = NU > 1 ? $clog2(NU) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic signed [DATA_W-1:0]  data_in,
  input  logic                      coeff_we,
  input  logic [AW-1:0]             coeff_addr,
  input  logic signed [COEFF_W-1:0] coeff_data,
  output logic                      out_valid,
  output logic signed [DATA_W-1:0]  data_out,
  output logic                      ovf
);
  localparam int PW = DATA_W + COEFF_W;
  localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'(OUT_SHIFT > 0) << (OUT_SHIFT > 0 ? OUT_SHIFT - 1 : 0);
  logic signed [PW-1:0] prod [NU];
  logic signed [ACC_W-1:0] chain [TAPS];
  logic v1, v2;
  logic signed [ACC_W:0] rounded, shifted;
  logic fits;
  logic signed [DATA_W-1:0] y;
  // Each unique coefficient feeds one multiplier; the product sees the pre-write coefficient.
  for (genvar j = 0; j < NU; j++) begin : g_coef
    logic signed [COEFF_W-1:0] c;
    logic signed [PW-1:0] p;
    always_ff @(posedge clk)
      if (reset) begin
        c <= '0;
        p <= '0;
      end else if (en) begin
        if (in_valid) p <= PW'(c) * PW'(data_in);
        if (coeff_we && 32'(coeff_addr) == j) c <= coeff_data;
      end
    assign prod[j] = p;
  end
  // Chain position i folds onto coefficient min(i, TAPS-1-i); the last position holds y.
  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    localparam int M = i < TAPS - 1 - i ? i : TAPS - 1 - i;
    logic signed [ACC_W-1:0] acc, prev;
    if (i == 0) begin : g_head
      assign prev = '0;
    end else begin : g_body
      assign prev = chain[i-1];
    end
    always_ff @(posedge clk)
      if (reset) acc <= '0;
      else if (en && v1) acc <= prev + ACC_W'(prod[M]);
    assign chain[i] = acc;
  end
  assign rounded = {chain[TAPS-1][ACC_W-1], chain[TAPS-1]} + RND;
  assign shifted = rounded >>> OUT_SHIFT;
  assign fits = &shifted[ACC_W:DATA_W-1] | ~|shifted[ACC_W:DATA_W-1];
  assign y = fits || SAT_EN == 0 ? shifted[DATA_W-1:0]
           : shifted[ACC_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  always_ff @(posedge clk)
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      data_out <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      v2 <= v1;
      out_valid <= v2;
      if (v2) begin
        data_out <= y;
        ovf <= !fits;
      end
    end
endmodule

// File: tb/tb_symmetric_fir_param.sv
// tb_symmetric_fir_param: scoreboard bench driving a saturating 5-tap and a wrapping 4-tap filter in parallel.
module tb_symmetric_fir_param;
  typedef struct packed {logic signed [15:0] x, c0, c1, c2;} smp_t;
  typedef struct packed {logic [15:0] y; logic o;} exp_t;
  logic clk = 0, reset = 1, en = 0, in_valid = 0, coeff_we = 0;
  logic [15:0] data_in = 0, coeff_data = 0;
  logic [1:0] coeff_addr = 0;
  logic ov [2];
  logic [15:0] dout [2];
  logic fl [2];
  logic [15:0] cs [2][3];
  smp_t h0[$], h1[$];
  exp_t q0[$], q1[$];
  int total = 0, bad = 0;
  logic en_s;

  always #5 clk = ~clk;

  symmetric_fir_param #(.DATA_W(16), .COEFF_W(16), .TAPS(5), .OUT_SHIFT(15), .SAT_EN(1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .data_in(data_in),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
    .out_valid(ov[0]), .data_out(dout[0]), .ovf(fl[0]));

  symmetric_fir_param #(.DATA_W(16), .COEFF_W(16), .TAPS(4), .OUT_SHIFT(15), .SAT_EN(0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .data_in(data_in),
    .coeff_we(coeff_we && coeff_addr < 2'd2), .coeff_addr(coeff_addr[0]), .coeff_data(coeff_data),
    .out_valid(ov[1]), .data_out(dout[1]), .ovf(fl[1]));

  // Direct convolution; each sample carries the coefficients in force when it was accepted.
  function automatic exp_t model(input smp_t h[$], input int taps, input bit sat);
    longint acc = 0, r;
    int j, n;
    logic signed [15:0] cf;
    exp_t e;
    n = h.size();
    for (int k = 0; k < taps && k < n; k++) begin
      j = k < taps - 1 - k ? k : taps - 1 - k;
      cf = j == 0 ? h[n-1-k].c0 : j == 1 ? h[n-1-k].c1 : h[n-1-k].c2;
      acc += longint'($signed(h[n-1-k].x)) * longint'($signed(cf));
    end
    r = (acc + 16384) >>> 15;
    e.o = r > 32767 || r < -32768;
    e.y = sat && r > 32767 ? 16'h7fff : sat && r < -32768 ? 16'h8000 : r[15:0];
    return e;
  endfunction

  task automatic chk(input string n, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endtask

  task automatic check(input int d, input logic [15:0] y, input logic o);
    exp_t e;
    total++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      bad++;
      $display("FAIL out_unexpected dut%0d got=%h want=none", d, y);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else e = q1.pop_front();
    if (y !== e.y || o !== e.o) begin
      bad++;
      $display("FAIL out dut%0d got y=%h ovf=%b want y=%h ovf=%b", d, y, o, e.y, e.o);
    end
  endtask

  always @(posedge clk) begin
    en_s = en;
    #1;
    if (en_s && ov[0] === 1'b1) check(0, dout[0], fl[0]);
    if (en_s && ov[1] === 1'b1) check(1, dout[1], fl[1]);
  end

  task automatic accept(input logic [15:0] x);
    h0.push_back({x, cs[0][0], cs[0][1], cs[0][2]});
    h1.push_back({x, cs[1][0], cs[1][1], 16'h0});
    if (h0.size() > 8) h0.delete(0);
    if (h1.size() > 8) h1.delete(0);
    q0.push_back(model(h0, 5, 1'b1));
    q1.push_back(model(h1, 4, 1'b0));
  endtask

  task automatic step(input logic e, input logic v, input logic [15:0] x,
                      input logic we, input logic [1:0] a, input logic [15:0] cd);
    @(negedge clk);
    en = e; in_valid = v; data_in = x; coeff_we = we; coeff_addr = a; coeff_data = cd;
    if (e && v) accept(x);
    if (e && we) begin
      if (a < 2'd3) cs[0][a] = cd;
      if (a < 2'd2) cs[1][a] = cd;
    end
  endtask

  task automatic load(input logic [1:0] a, input logic [15:0] cd);
    step(1'b1, 1'b0, 16'h0, 1'b1, a, cd);
  endtask

  task automatic zeros(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b1, 16'h0, 1'b0, 2'd0, 16'h0);
  endtask

  task automatic rnd(input int n);
    for (int k = 0; k < n; k++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, 16'($urandom),
           $urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)), 16'($urandom));
  endtask

  // Reset is asserted with en low and competing writes/samples to show it dominates.
  task automatic do_reset;
    @(negedge clk);
    reset = 1; en = 0; in_valid = 1; coeff_we = 1; coeff_addr = 0; coeff_data = 16'h7fff;
    @(negedge clk);
    reset = 0; en = 1; in_valid = 0; coeff_we = 0;
    q0.delete(); q1.delete(); h0.delete(); h1.delete();
    for (int d = 0; d < 2; d++) for (int j = 0; j < 3; j++) cs[d][j] = 16'h0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_valid%0d", d), {15'h0, ov[d]}, 16'h0);
      chk($sformatf("rst_data%0d", d), dout[d], 16'h0);
      chk($sformatf("rst_ovf%0d", d), {15'h0, fl[d]}, 16'h0);
    end
  endtask

  initial begin
    do_reset;
    load(0, 16'h4000); load(1, 16'h2000); load(2, 16'h4000); load(3, 16'h7fff);
    step(1'b1, 1'b1, 16'h4000, 1'b0, 2'd0, 16'h0);
    zeros(1); chk("lat_e1", {15'h0, ov[0]}, 16'h0);
    zeros(1); chk("lat_e2", {15'h0, ov[0]}, 16'h0);
    zeros(1); chk("lat_e3", {15'h0, ov[0]}, 16'h1);
    zeros(2);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 16'($urandom), 1'b1, 2'd0, 16'h1234);
    zeros(4);
    step(1'b1, 1'b1, 16'h4000, 1'b0, 2'd0, 16'h0);
    for (int k = 0; k < 10; k++) step(1'b1, k[0], k[0] ? 16'h0 : 16'($urandom), 1'b0, 2'd0, 16'h0);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 16'h7fff, 1'b0, 2'd0, 16'h0);
    zeros(6);
    load(0, 16'h0800); load(1, 16'h1000); load(2, 16'h2000);
    step(1'b1, 1'b1, 16'h7fff, 1'b0, 2'd0, 16'h0);
    zeros(6);
    step(1'b1, 1'b1, 16'h3000, 1'b1, 2'd0, 16'h7000);
    zeros(6);
    rnd(400);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 16'($urandom), 1'b0, 2'd0, 16'h0);
    do_reset;
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 16'($urandom), 1'b0, 2'd0, 16'h0);
    for (int j = 0; j < 3; j++) load(2'(j), 16'($urandom_range(0, 16'h3fff)));
    rnd(200);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 16'h0, 1'b0, 2'd0, 16'h0);
    chk("drain0", 16'(q0.size()), 16'h0);
    chk("drain1", 16'(q1.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
